// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory controller port between data (port 0)
// and fetch (port 1) requesters with a starvation guard and timeout.
// Ports: i_clk/i_rst (sync active-low); per-port i_req_x/i_addr_x
// (+ i_wdata_0/i_we_0), o_gnt_x/o_valid_x/o_rdata_x/o_err_x/o_stall_x;
// memory side o_mem_req/addr/wdata/we, i_mem_ready/i_mem_rdata.
module mem_arbiter #(
  parameter int MAX_DATA_RUN = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_0,
  input  logic [31:0] i_addr_0,
  input  logic [31:0] i_wdata_0,
  input  logic        i_we_0,
  output logic        o_gnt_0,
  output logic        o_valid_0,
  output logic [31:0] o_rdata_0,
  output logic        o_err_0,
  output logic        o_stall_0,
  input  logic        i_req_1,
  input  logic [31:0] i_addr_1,
  output logic        o_gnt_1,
  output logic        o_valid_1,
  output logic [31:0] o_rdata_1,
  output logic        o_err_1,
  output logic        o_stall_1,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_we,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_BUSY_0, S_BUSY_1, S_RESP_0, S_RESP_1
  } state_t;

  localparam logic [3:0] RUN_MAX  = 4'(MAX_DATA_RUN);
  localparam bit         TMO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] TMO_LAST =
    8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_gnt_0;
  logic        w_gnt_1;
  logic        w_done;
  logic        w_tmo;
  logic        w_tmo_hit;
  logic        w_busy_0;
  logic        w_busy_1;
  logic [3:0]  r_run;
  logic [7:0]  r_tmo;
  logic        r_gnt_0;
  logic        r_gnt_1;
  logic        r_valid_0;
  logic        r_valid_1;
  logic        r_err_0;
  logic        r_err_1;
  logic [31:0] r_rdata_0;
  logic [31:0] r_rdata_1;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_we;

  assign w_busy_0  = (r_state == S_BUSY_0);
  assign w_busy_1  = (r_state == S_BUSY_1);
  assign w_tmo_hit = TMO_EN && (r_tmo == TMO_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_0     = 1'b0;
    w_gnt_1     = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // Port 0 wins ties until it has used up its run budget.
        if (i_req_0 && (!i_req_1 || r_run != RUN_MAX)) begin
          w_gnt_0     = 1'b1;
          w_state_nxt = S_BUSY_0;
        end else if (i_req_1) begin
          w_gnt_1     = 1'b1;
          w_state_nxt = S_BUSY_1;
        end
      end
      S_BUSY_0, S_BUSY_1: begin
        if (i_mem_ready)    w_done = 1'b1;
        else if (w_tmo_hit) w_tmo  = 1'b1;
        if (w_done || w_tmo)
          w_state_nxt = w_busy_0 ? S_RESP_0 : S_RESP_1;
      end
      S_RESP_0, S_RESP_1: w_state_nxt = S_IDLE;
      default:            w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_gnt_0     <= 1'b0;
      r_gnt_1     <= 1'b0;
      r_valid_0   <= 1'b0;
      r_valid_1   <= 1'b0;
      r_err_0     <= 1'b0;
      r_err_1     <= 1'b0;
      r_rdata_0   <= '0;
      r_rdata_1   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_run       <= '0;
      r_tmo       <= '0;
    end else begin
      r_gnt_0   <= w_gnt_0;
      r_gnt_1   <= w_gnt_1;
      r_valid_0 <= (w_done | w_tmo) & w_busy_0;
      r_valid_1 <= (w_done | w_tmo) & w_busy_1;
      r_err_0   <= w_tmo & w_busy_0;
      r_err_1   <= w_tmo & w_busy_1;
      if (w_done && w_busy_0 && !r_mem_we)
        r_rdata_0 <= i_mem_rdata;
      if (w_done && w_busy_1)
        r_rdata_1 <= i_mem_rdata;
      if (w_gnt_0) begin
        r_mem_req   <= 1'b1;
        r_mem_addr  <= i_addr_0;
        r_mem_wdata <= i_wdata_0;
        r_mem_we    <= i_we_0;
        r_tmo       <= '0;
      end else if (w_gnt_1) begin
        r_mem_req   <= 1'b1;
        r_mem_addr  <= i_addr_1;
        r_mem_wdata <= '0;
        r_mem_we    <= 1'b0;
        r_tmo       <= '0;
      end else if (w_done || w_tmo) begin
        r_mem_req <= 1'b0;
      end else if (w_busy_0 || w_busy_1) begin
        r_tmo <= r_tmo + 8'd1;
      end
      if (w_gnt_0) begin
        if (!i_req_1)
          r_run <= '0;
        else if (r_run < RUN_MAX)
          r_run <= r_run + 4'd1;
      end else if (w_gnt_1) begin
        r_run <= '0;
      end
    end
  end

  assign o_gnt_0     = r_gnt_0;
  assign o_gnt_1     = r_gnt_1;
  assign o_valid_0   = r_valid_0;
  assign o_valid_1   = r_valid_1;
  assign o_err_0     = r_err_0;
  assign o_err_1     = r_err_1;
  assign o_rdata_0   = r_rdata_0;
  assign o_rdata_1   = r_rdata_1;
  assign o_mem_req   = r_mem_req;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_we    = r_mem_we;
  assign o_stall_0   = i_req_0 & ~r_valid_0;
  assign o_stall_1   = i_req_1 & ~r_valid_1;

endmodule
